// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: merges CPU instruction fetches (two beats) and data accesses onto
// one single-outstanding memory port. Optional one-entry fetch buffer: BUS_ARB_FETCH_HIT_EN.
module cpu_bus_arbiter #(
   parameter bit          DATA_PRIORITY  = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_WORD       = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        inst_ce,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic [31:0] inst_rdata_2,
   output logic        inst_stall,

   input  logic        data_ce,
   input  logic        data_we,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_stall,

   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,

   output logic        bus_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_I0,
      S_I1,
      S_D,
      S_IRSP,
      S_DRSP
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic        r_last_data;
   logic [7:0]  r_tmo_cnt;

   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic        r_bus_error;

   logic [31:0] r_inst_rdata;
   logic [31:0] r_inst_rdata_2;
   logic [31:0] r_data_rdata;

   logic [31:0] w_line_addr;
   logic        w_grant_inst;
   logic        w_grant_data;
   logic        w_timeout;
   logic        w_beat_done;
   logic        w_hit;
   logic [31:0] w_buf_w0;
   logic [31:0] w_buf_w1;
   logic        w_unused;

   assign w_line_addr = {inst_addr[31:2], 2'b00};
   assign w_unused    = &{1'b0, inst_addr[1:0]};

   // A data grant last time hands the next contested IDLE cycle to the fetch side.
   assign w_grant_inst = inst_ce & (~data_ce | r_last_data | (DATA_PRIORITY == 1'b0));
   assign w_grant_data = data_ce & ~w_grant_inst;

   assign w_timeout   = r_mem_req & ~mem_ack & (r_tmo_cnt == TMO_LAST);
   assign w_beat_done = r_mem_req & (mem_ack | w_timeout);

   assign inst_stall = inst_ce & (r_state != S_IRSP);
   assign data_stall = data_ce & (r_state != S_DRSP);

   assign mem_req      = r_mem_req;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_be       = r_mem_be;
   assign mem_wdata    = r_mem_wdata;
   assign bus_error    = r_bus_error;
   assign inst_rdata   = r_inst_rdata;
   assign inst_rdata_2 = r_inst_rdata_2;
   assign data_rdata   = r_data_rdata;

   // Beat watchdog: restarts on every new beat and whenever no beat is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_mem_req && !w_beat_done) begin
         r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end else begin
         r_tmo_cnt <= '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values of its neighbours regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_last_data    <= 1'b0;
         r_mem_req      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_be       <= '0;
         r_mem_wdata    <= '0;
         r_bus_error    <= 1'b0;
         r_inst_rdata   <= '0;
         r_inst_rdata_2 <= '0;
         r_data_rdata   <= '0;
      end else begin
         r_bus_error <= w_timeout;
         unique case (r_state)
            S_IDLE: begin
               if (w_grant_inst) begin
                  r_last_data <= 1'b0;
                  if (w_hit) begin
                     r_state        <= S_IRSP;
                     r_inst_rdata   <= w_buf_w0;
                     r_inst_rdata_2 <= w_buf_w1;
                  end else begin
                     r_state    <= S_I0;
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= w_line_addr;
                     r_mem_be   <= 4'hF;
                  end
               end else if (w_grant_data) begin
                  r_last_data <= 1'b1;
                  r_state     <= S_D;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= data_we;
                  r_mem_addr  <= data_addr;
                  r_mem_be    <= data_be;
                  r_mem_wdata <= data_wdata;
               end
            end

            S_I0: begin
               if (w_beat_done) begin
                  r_inst_rdata <= mem_ack ? mem_rdata : ERR_WORD;
                  r_mem_addr   <= r_mem_addr + 32'd4;
                  r_state      <= S_I1;
               end
            end

            S_I1: begin
               if (w_beat_done) begin
                  r_inst_rdata_2 <= mem_ack ? mem_rdata : ERR_WORD;
                  r_mem_req      <= 1'b0;
                  r_state        <= S_IRSP;
               end
            end

            S_D: begin
               if (w_beat_done) begin
                  if (!r_mem_we) begin
                     r_data_rdata <= mem_ack ? mem_rdata : ERR_WORD;
                  end
                  r_mem_req <= 1'b0;
                  r_state   <= S_DRSP;
               end
            end

            S_IRSP, S_DRSP: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state   <= S_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef BUS_ARB_FETCH_HIT_EN
   logic        r_buf_valid;
   logic        r_fetch_err;
   logic [31:0] r_buf_tag;
   logic [31:0] r_fetch_tag;
   logic [31:0] r_buf_w0;
   logic [31:0] r_buf_w1;

   // A fetch that timed out on either beat must never populate the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf_valid <= 1'b0;
         r_fetch_err <= 1'b0;
         r_buf_tag   <= '0;
         r_fetch_tag <= '0;
         r_buf_w0    <= '0;
         r_buf_w1    <= '0;
      end else begin
         if (r_state == S_IDLE && w_grant_inst) begin
            r_fetch_tag <= w_line_addr;
            r_fetch_err <= 1'b0;
         end else if (w_timeout) begin
            r_fetch_err <= 1'b1;
         end

         if (w_timeout) begin
            r_buf_valid <= 1'b0;
         end else if (r_state == S_IRSP && !r_fetch_err) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_fetch_tag;
            r_buf_w0    <= r_inst_rdata;
            r_buf_w1    <= r_inst_rdata_2;
         end else if (r_state == S_DRSP && r_mem_we &&
                      (r_mem_addr == r_buf_tag || r_mem_addr == r_buf_tag + 32'd4)) begin
            r_buf_valid <= 1'b0;
         end
      end
   end

   assign w_hit    = r_buf_valid & (r_buf_tag == w_line_addr);
   assign w_buf_w0 = r_buf_w0;
   assign w_buf_w1 = r_buf_w1;
`else
   assign w_hit    = 1'b0;
   assign w_buf_w0 = '0;
   assign w_buf_w1 = '0;
`endif

endmodule
